write_ptr_full_logic: RTL and testbench
=======================================

Name: write_ptr_full_logic

Overview:
Write-side pointer and full-flag logic for the asynchronous FIFO. It is the counterpart of the read-pointer/empty block.
- Owns the binary and Gray write pointers and produces the memory write address.
- Synchronises the read-domain Gray pointer into wclk and computes a registered full flag.
- Gates writes so that data is never accepted while the FIFO is full.

Parameters:
address, 2, address-parameter convention of the FIFO; pointer width PW = address+2 bits (MSB is the wrap bit), memory index = address+1 bits, DEPTH = 2^(address+1) (8 at default).
AF_THRESH, 6, fill level at or above which almost_full asserts (used only with WR_ALMOST_FULL_EN); legal range 1..DEPTH.

Ports:
wclk  input  1  write-domain clock; all logic on posedge.
w_rst  input  1  synchronous active-high reset.
w_en  input  1  write request from the producer.
read_ptr_gray  input  PW  Gray-coded read pointer, launched from the read-clock domain (asynchronous to wclk).
write_ptr  output  PW  binary write pointer (registered).
write_ptr_gray  output  PW  Gray write pointer (registered), sent to the read domain.
waddr  output  address+1  memory write index = write_ptr[address:0].
wr_fire  output  1  combinational w_en & ~full; this is the memory write strobe.
full  output  1  registered full flag.
overflow  output  1  sticky flag: a write was attempted while full.
almost_full  output  1  registered almost-full flag (constant 0 without WR_ALMOST_FULL_EN).

Behaviour:
- Reset (w_rst=1 at posedge wclk): write_ptr=0, write_ptr_gray=0, both synchroniser stages=0, full=0, overflow=0, almost_full=0. Reset takes priority over every other event in the same cycle, including w_en.
- Synchroniser: two-flop chain rq1 <= read_ptr_gray; rq2 <= rq1. Only rq2 is used by the logic. A read-pointer change becomes visible in full 2 wclk edges after it is sampled.
- Next-pointer computation:
  - wbin_next = write_ptr + wr_fire, modulo 2^PW; it wraps naturally from all-ones to 0.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - The registers load wbin_next and wgray_next every cycle.
- Full computation:
  - full <= (wgray_next == {~rq2[PW-1:PW-2], rq2[PW-3:0]}).
  - full therefore asserts on the edge that accepts the DEPTH-th outstanding write, i.e. 0 cycles after the write, visible in the next cycle.
- Write gating: when w_en=1 and full=1, the write is dropped, pointers hold, wr_fire=0, and overflow is set to 1. overflow clears only on w_rst.
- Deassertion: full drops only after the synchronised read pointer advances. full is pessimistic; it never falsely deasserts.
- Simultaneous write and read-pointer advance: both are used in the same cycle's compare, so the outcome is full only if wgray_next still equals the inverted-MSBs compare of the new rq2.
- Gray output: write_ptr_gray changes at most 1 bit per wclk cycle.
- Reset mid-operation: all state clears in one cycle. The read domain must be reset concurrently; that is a system-level requirement.

Optional Feature:
WR_ALMOST_FULL_EN
- Defined:
  - rbin = Gray-to-binary of rq2.
  - level_next = wbin_next - rbin, PW-bit modulo.
  - almost_full <= (level_next >= AF_THRESH).
  - Reset value is 0. The flag uses the same synchroniser pessimism as full.
- Undefined: almost_full is tied to 1'b0 and no Gray-to-binary logic is generated.

Decomposition:
- Shared package fifo_pkg: PW / DEPTH derivation functions, bin2gray and gray2bin functions. These are reused by the read-side block.
- One sub-module, ptr_sync_2ff: a parameterised-width two-flop synchroniser with synchronous active-high reset. The read side will instantiate it for the write pointer.

Test Plan:
1. Reset: hold w_rst=1 for 2 cycles with w_en=1, then release -> write_ptr=0, write_ptr_gray=0, full=0, overflow=0, wr_fire=1 only after release.
2. Fill (address=2): read_ptr_gray=0, 8 consecutive writes -> write_ptr=4'b1000, write_ptr_gray=4'b1100, full=1 in the cycle after the 8th write.
3. Overflow: while full, w_en=1 for 3 cycles -> wr_fire=0, write_ptr stays 8, overflow=1 and remains 1 after w_en drops.
4. Drain: set read_ptr_gray=4'b0001 (rbin=1) -> full=0 exactly 2 wclk later; one write is then accepted, write_ptr=9, full=1 again.
5. Wrap: stream reads and writes until write_ptr passes 15->0 -> write_ptr_gray goes 4'b1000->4'b0000; full is correct across the wrap; single-bit Gray change checked every cycle.
6. Almost-full with WR_ALMOST_FULL_EN, AF_THRESH=6: read_ptr_gray=0, 5 writes -> almost_full=0; 6th write -> almost_full=1; macro undefined -> almost_full stays 0 throughout.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width, depth and Gray-code conversion.
// Used by both the write-side and read-side pointer blocks.
package fifo_pkg;

    function automatic int pw_of(input int address);
        return address + 2;
    endfunction

    function automatic int depth_of(input int address);
        return 1 << (address + 1);
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Synchronous active-high reset clears both stages.
module ptr_sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q1;

    // Two-stage capture; only the second stage is safe to consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/write_ptr_full_logic.sv
// Write-side pointer, full flag and overflow tracking for the async FIFO.
// Optional WR_ALMOST_FULL_EN adds a registered almost_full flag.
module write_ptr_full_logic
    import fifo_pkg::*;
#(
    parameter int address   = 2,
    parameter int AF_THRESH = 6
) (
    input  logic               wclk,
    input  logic               w_rst,
    input  logic               w_en,
    input  logic [address+1:0] read_ptr_gray,
    output logic [address+1:0] write_ptr,
    output logic [address+1:0] write_ptr_gray,
    output logic [address:0]   waddr,
    output logic               wr_fire,
    output logic               full,
    output logic               overflow,
    output logic               almost_full
);

    localparam int PW    = pw_of(address);
    localparam int DEPTH = depth_of(address);

    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_thresh
        $error("AF_THRESH must lie in 1..DEPTH");
    end

    logic [PW-1:0] rq2;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] full_cmp;

    ptr_sync_2ff #(.W(PW)) u_rsync (
        .clk (wclk),
        .rst (w_rst),
        .d   (read_ptr_gray),
        .q   (rq2)
    );

    // The memory must never see a write strobe while the block is in reset.
    assign wr_fire    = w_en & ~full & ~w_rst;
    assign wbin_next  = write_ptr + PW'(wr_fire);
    assign wgray_next = PW'(bin2gray(32'(wbin_next)));
    assign full_cmp   = {~rq2[PW-1:PW-2], rq2[PW-3:0]};
    assign waddr      = write_ptr[address:0];

    // Pointer registers, pessimistic full flag and sticky overflow.
    always_ff @(posedge wclk) begin
        if (w_rst) begin
            write_ptr      <= '0;
            write_ptr_gray <= '0;
            full           <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            write_ptr      <= wbin_next;
            write_ptr_gray <= wgray_next;
            full           <= (wgray_next == full_cmp);
            if (w_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef WR_ALMOST_FULL_EN
    logic [PW-1:0] rbin;
    logic [PW-1:0] level_next;

    assign rbin       = PW'(gray2bin(32'(rq2)));
    assign level_next = wbin_next - rbin;

    // Fill level against the synchronised read pointer, so it lags like full.
    always_ff @(posedge wclk) begin
        if (w_rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (level_next >= PW'(AF_THRESH));
        end
    end
`else
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_write_ptr_full_logic.sv
// Scoreboard bench for write_ptr_full_logic: directed cycles push expected
// outputs; a negedge monitor pops and compares them.
module tb_write_ptr_full_logic;

    typedef struct {
        string      name;
        logic [3:0] wp;
        logic       full;
        logic       ovf;
        logic       fire;
        logic       af;
    } exp_t;

    logic       wclk;
    logic       w_rst;
    logic       w_en;
    logic [3:0] read_ptr_gray;
    logic [3:0] write_ptr;
    logic [3:0] write_ptr_gray;
    logic [2:0] waddr;
    logic       wr_fire;
    logic       full;
    logic       overflow;
    logic       almost_full;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    write_ptr_full_logic dut (
        .wclk           (wclk),
        .w_rst          (w_rst),
        .w_en           (w_en),
        .read_ptr_gray  (read_ptr_gray),
        .write_ptr      (write_ptr),
        .write_ptr_gray (write_ptr_gray),
        .waddr          (waddr),
        .wr_fire        (wr_fire),
        .full           (full),
        .overflow       (overflow),
        .almost_full    (almost_full)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic drive(input bit rst, input bit en, input logic [3:0] rpg,
                         input logic [3:0] wp, input bit f, input bit ov,
                         input bit fi, input bit afv, input string nm);
        exp_t e;
        @(posedge wclk);
        #1;
        w_rst = rst;
        w_en = en;
        read_ptr_gray = rpg;
        e.name = nm;
        e.wp = wp;
        e.full = f;
        e.ovf = ov;
        e.fire = fi;
`ifdef WR_ALMOST_FULL_EN
        e.af = afv;
`else
        e.af = 1'b0;
`endif
        q.push_back(e);
    endtask

    // Monitor: compare each presented cycle and check single-bit Gray steps.
    initial begin
        exp_t e;
        logic [3:0] prev_g;
        bit have_prev;
        have_prev = 0;
        prev_g = '0;
        forever begin
            @(negedge wclk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (write_ptr !== e.wp || write_ptr_gray !== g(e.wp) ||
                    waddr !== e.wp[2:0] || full !== e.full ||
                    overflow !== e.ovf || wr_fire !== e.fire ||
                    almost_full !== e.af) begin
                    miscompares++;
                    $display("FAIL %s: got wp=%h wg=%h wa=%h full=%b ovf=%b fire=%b af=%b, want wp=%h wg=%h wa=%h full=%b ovf=%b fire=%b af=%b",
                             e.name, write_ptr, write_ptr_gray, waddr, full,
                             overflow, wr_fire, almost_full, e.wp, g(e.wp),
                             e.wp[2:0], e.full, e.ovf, e.fire, e.af);
                end
                if (have_prev) begin
                    vectors++;
                    if ($countones(write_ptr_gray ^ prev_g) > 1) begin
                        miscompares++;
                        $display("FAIL gray_step %s: got %b after %b, want at most 1 bit change",
                                 e.name, write_ptr_gray, prev_g);
                    end
                end
                prev_g = write_ptr_gray;
                have_prev = 1;
            end
        end
    end

    initial begin
        int budget;
        w_rst = 1'b1;
        w_en = 1'b1;
        read_ptr_gray = 4'b0000;

        drive(1, 1, 4'b0000, 4'd0, 0, 0, 0, 0, "rst0");
        drive(1, 1, 4'b0000, 4'd0, 0, 0, 0, 0, "rst1");

        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 4'b0000, 4'(k), 0, 0, 1, k >= 6, "fill");
        end

        drive(0, 1, 4'b0000, 4'd8, 1, 0, 0, 1, "ovf0");
        drive(0, 1, 4'b0000, 4'd8, 1, 1, 0, 1, "ovf1");
        drive(0, 1, 4'b0000, 4'd8, 1, 1, 0, 1, "ovf2");
        drive(0, 0, 4'b0000, 4'd8, 1, 1, 0, 1, "ovf_hold");

        drive(0, 0, 4'b0001, 4'd8, 1, 1, 0, 1, "drain0");
        drive(0, 0, 4'b0001, 4'd8, 1, 1, 0, 1, "drain1");
        drive(0, 0, 4'b0001, 4'd8, 1, 1, 0, 1, "drain2");
        drive(0, 1, 4'b0001, 4'd8, 0, 1, 1, 1, "drain_open");
        drive(0, 0, 4'b0001, 4'd9, 1, 1, 0, 1, "refull");

        drive(0, 0, 4'b1101, 4'd9, 1, 1, 0, 1, "catch0");
        drive(0, 0, 4'b1101, 4'd9, 1, 1, 0, 1, "catch1");
        drive(0, 0, 4'b1101, 4'd9, 1, 1, 0, 1, "catch2");
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 4'b1101, 4'(9 + i), 0, 1, 1, i >= 6, "wrap");
        end
        drive(0, 1, 4'b1101, 4'd1, 1, 1, 0, 1, "wrap_full");

        drive(1, 1, 4'b1101, 4'd1, 1, 1, 0, 1, "rst_mid");
        drive(0, 0, 4'b1101, 4'd0, 0, 0, 0, 0, "rst_clear");

        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(posedge wclk);
            budget++;
        end
        @(posedge wclk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain_queue: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
